// File: rtl/btn_debounce_pkg.sv
// lscc_btn_pkg: shared types and constants for the push-button input conditioner.
//   btn_state_e : per-channel debounce FSM states
//   TICK_HZ     : rate of the shared debounce tick (1 ms)
package lscc_btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_e;

    localparam int TICK_HZ = 1000;

endpackage

// File: rtl/btn_debounce_channel.sv
// btn_channel: one button channel -- 2-flop synchroniser, debounce FSM, hold counter.
//   clk_i, rstn_i : clock, synchronous active-low reset
//   tick_i        : shared debounce tick, one cycle per ms
//   btn_i         : raw asynchronous board input
//   level_o       : debounced state, 1 = pressed
//   press_o       : one-cycle pulse on accepted press
//   release_o     : one-cycle pulse on accepted release
//   long_o        : one-cycle pulse once per press after LONG_PRESS_MS held ticks
module btn_channel
    import lscc_btn_pkg::*;
#(
    parameter logic BTN_POLARITY  = 1'b0,
    parameter int   DEBOUNCE_MS   = 10,
    parameter int   LONG_PRESS_MS = 1000
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int              HW    = $clog2(LONG_PRESS_MS + 1);
    localparam logic [7:0]      DLAST = 8'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0]   HMAX  = HW'(LONG_PRESS_MS);
    localparam logic [HW-1:0]   HLAST = HW'(LONG_PRESS_MS - 1);

    logic [1:0]    sync;
    logic          act;
    btn_state_e    state;
    logic [7:0]    dcnt;
    logic [HW-1:0] hcnt;
    logic          long_done;
    logic          long_hit;

    assign act      = (sync[1] == BTN_POLARITY);
    // hcnt is about to reach LONG_PRESS_MS on this tick
    assign long_hit = tick_i && (hcnt == HLAST) && !long_done;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync      <= {2{~BTN_POLARITY}};
            state     <= IDLE;
            dcnt      <= '0;
            hcnt      <= '0;
            long_done <= 1'b0;
            level_o   <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
        end else begin
            sync      <= {sync[0], btn_i};
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (act) begin
                        state <= PRESS_WAIT;
                        dcnt  <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!act) begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end else if (tick_i) begin
                        if (dcnt == DLAST) begin
                            state     <= HELD;
                            dcnt      <= '0;
                            level_o   <= 1'b1;
                            press_o   <= 1'b1;
                            hcnt      <= '0;
                            long_done <= 1'b0;
                        end else begin
                            dcnt <= dcnt + 8'd1;
                        end
                    end
                end
                HELD: begin
                    // The cycle in which act drops still counts as held time.
                    if (tick_i && hcnt != HMAX)
                        hcnt <= hcnt + 1'b1;
                    if (long_hit) begin
                        long_o    <= 1'b1;
                        long_done <= 1'b1;
                    end
                    if (!act) begin
                        state <= RELEASE_WAIT;
                        dcnt  <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // hcnt and long_done are kept so a glitch only pauses the hold timer.
                    if (act) begin
                        state <= HELD;
                    end else if (tick_i) begin
                        if (dcnt == DLAST) begin
                            state     <= IDLE;
                            dcnt      <= '0;
                            level_o   <= 1'b0;
                            release_o <= 1'b1;
                        end else begin
                            dcnt <= dcnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: multi-channel button conditioner with shared 1 ms tick.
//   clk_i, rstn_i : clock, synchronous active-low reset
//   btn_i         : raw asynchronous inputs, active level BTN_POLARITY
//   level_o       : debounced level per channel, 1 = pressed
//   press_o       : one-cycle press pulses
//   release_o     : one-cycle release pulses
//   long_o        : one-cycle long-press pulses
module btn_debounce
    import lscc_btn_pkg::*;
#(
    parameter int   CLK_IN_MHZ    = 125,
    parameter int   NUM_BTN       = 4,
    parameter logic BTN_POLARITY  = 1'b0,
    parameter int   DEBOUNCE_MS   = 10,
    parameter int   LONG_PRESS_MS = 1000
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] level_o,
    output logic [NUM_BTN-1:0] press_o,
    output logic [NUM_BTN-1:0] release_o,
    output logic [NUM_BTN-1:0] long_o
);

    logic tick;

`ifdef SIM
    assign tick = 1'b1;
`else
    localparam int          DIV = CLK_IN_MHZ * (1_000_000 / TICK_HZ);
    localparam int          PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] TC = PW'(DIV - 1);

    logic [PW-1:0] pcnt;

    assign tick = (pcnt == TC);

    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            pcnt <= '0;
        else
            pcnt <= tick ? '0 : pcnt + 1'b1;
    end
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .BTN_POLARITY  (BTN_POLARITY),
            .DEBOUNCE_MS   (DEBOUNCE_MS),
            .LONG_PRESS_MS (LONG_PRESS_MS)
        ) u_ch (
            .clk_i     (clk_i),
            .rstn_i    (rstn_i),
            .tick_i    (tick),
            .btn_i     (btn_i[i]),
            .level_o   (level_o[i]),
            .press_o   (press_o[i]),
            .release_o (release_o[i]),
            .long_o    (long_o[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed and random stimulus against a run-length reference model.
module tb_btn_debounce;

`ifdef SIM
    localparam int P        = 1;
    localparam int D        = 4;
    localparam int L        = 16;
    localparam int RAND_CYC = 6000;
`else
    localparam int P        = 1000;
    localparam int D        = 2;
    localparam int L        = 6;
    localparam int RAND_CYC = 15000;
`endif
    localparam int   N   = 4;
    localparam logic POL = 1'b0;
    localparam int   ACC = (D + 1) * P + 5;

    logic         clk_i  = 1'b0;
    logic         rstn_i = 1'b0;
    logic [N-1:0] btn_i  = '1;
    logic [N-1:0] level_o, press_o, release_o, long_o;

    btn_debounce #(
        .CLK_IN_MHZ    (1),
        .NUM_BTN       (N),
        .BTN_POLARITY  (POL),
        .DEBOUNCE_MS   (D),
        .LONG_PRESS_MS (L)
    ) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .btn_i     (btn_i),
        .level_o   (level_o),
        .press_o   (press_o),
        .release_o (release_o),
        .long_o    (long_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    logic [N-1:0] d1, d2, m_lvl, m_press, m_rel, m_long;
    int pc;
    bit mm [N];
    int mt [N];
    int hc [N];
    bit ld [N];

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // A level change is accepted once the opposite level has been seen for one
    // cycle and then persisted for D further ticks. Hold time counts ticks while
    // pressed and not in a pending-release run.
    task automatic model_edge();
        logic [N-1:0] act;
        bit tick;
        if (!rstn_i) begin
            d1 = '0; d2 = '0; pc = 0;
            m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
            for (int i = 0; i < N; i++) begin
                mm[i] = 0; mt[i] = 0; hc[i] = 0; ld[i] = 0;
            end
            return;
        end
        act  = d2;
        tick = (pc == P - 1);
        pc   = tick ? 0 : pc + 1;
        d2   = d1;
        d1   = ~(btn_i ^ {N{POL}});
        m_press = '0; m_rel = '0; m_long = '0;
        for (int i = 0; i < N; i++) begin
            if (m_lvl[i] && !mm[i] && tick && hc[i] < L) begin
                hc[i] = hc[i] + 1;
                if (hc[i] == L && !ld[i]) begin
                    m_long[i] = 1'b1;
                    ld[i] = 1;
                end
            end
            if (act[i] == m_lvl[i]) begin
                mm[i] = 0; mt[i] = 0;
            end else if (!mm[i]) begin
                mm[i] = 1; mt[i] = 0;
            end else if (tick) begin
                mt[i] = mt[i] + 1;
                if (mt[i] == D) begin
                    m_lvl[i] = ~m_lvl[i];
                    if (m_lvl[i]) begin
                        m_press[i] = 1'b1; hc[i] = 0; ld[i] = 0;
                    end else begin
                        m_rel[i] = 1'b1;
                    end
                    mm[i] = 0; mt[i] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        check("level", level_o, m_lvl);
        check("press", press_o, m_press);
        check("release", release_o, m_rel);
        check("long", long_o, m_long);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    int rem [N];

    initial begin
        // reset with buttons idle
        rstn_i = 1'b0; btn_i = '1;
        run(5);
        rstn_i = 1'b1;
        run(20);
        // clean press/release on channel 0
        btn_i[0] = 1'b0; run(ACC + 1);
        btn_i[0] = 1'b1; run(ACC + 1);
        // bounce on channel 1
        for (int k = 0; k < 10; k++) begin
            btn_i[1] = ~btn_i[1]; run(2);
        end
        btn_i[1] = 1'b0; run(ACC);
        btn_i[1] = 1'b1; run(ACC);
        // long press with a short release glitch mid-hold on channel 2
        btn_i[2] = 1'b0; run((D + 2) * P + (L / 2) * P);
        btn_i[2] = 1'b1; run(2);
        btn_i[2] = 1'b0; run((L + 2) * P + 5);
        btn_i[2] = 1'b1; run(ACC);
        // all channels together, then channel 3 alone released
        btn_i = '0;       run(ACC);
        btn_i[3] = 1'b1;  run(ACC);
        btn_i = '1;       run(ACC);
        // reset while channel 0 is held
        btn_i[0] = 1'b0; run(ACC);
        rstn_i = 1'b0;   run(2);
        rstn_i = 1'b1;   run(ACC);
        btn_i[0] = 1'b1; run(ACC);
        // random bouncing and holds on every channel, occasional resets
        for (int i = 0; i < N; i++) rem[i] = 1;
        for (int c = 0; c < RAND_CYC; c++) begin
            rstn_i = ($urandom_range(0, 1499) != 0);
            for (int i = 0; i < N; i++) begin
                rem[i] = rem[i] - 1;
                if (rem[i] == 0) begin
                    btn_i[i] = ~btn_i[i];
                    rem[i] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 3 * P))
                                                          : int'($urandom_range(D * P, (L + D + 3) * P));
                end
            end
            step();
        end
        rstn_i = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Multi-channel push-button/DIP-switch input conditioner: the input-side counterpart to the board's LED display drivers. It synchronises raw board inputs into `clk_i`, debounces each channel on a shared 1 ms tick, and emits a clean level plus single-cycle press, release and long-press pulses. Downstream consumers are the display and sequencer blocks, for example for mode or speed selection.

## Interface
- `CLK_IN_MHZ`, 125: input clock frequency, sets the 1 ms tick prescaler.
- `NUM_BTN`, 4: number of independent input channels.
- `BTN_POLARITY`, 1'b0: active level of `btn_i` (0 = pressed pulls low).
- `DEBOUNCE_MS`, 10: ticks an input must be stable before it is accepted; range 1..255.
- `LONG_PRESS_MS`, 1000: held ticks before `long_o` fires; range must exceed `DEBOUNCE_MS`.
- `clk_i` input 1: system clock.
- `rstn_i` input 1: reset, synchronous, active-low.
- `btn_i` input NUM_BTN: raw asynchronous board inputs.
- `level_o` output NUM_BTN: debounced state, 1 = pressed, regardless of `BTN_POLARITY`.
- `press_o` output NUM_BTN: one-cycle pulse on accepted press.
- `release_o` output NUM_BTN: one-cycle pulse on accepted release.
- `long_o` output NUM_BTN: one-cycle pulse once per press after `LONG_PRESS_MS` held ticks.

## Operation
- **Synchroniser.** Two flops per channel.
  - Reset value is the inactive level (`~BTN_POLARITY`), so no spurious press occurs out of reset.
  - `act = (sync == BTN_POLARITY)`.
- **Tick.**
  - In normal builds, a prescaler counts 0..CLK_IN_MHZ*1000-1 and asserts `tick` for one cycle at terminal count.
  - With `SIM` defined, `tick` is constantly 1.
- **Per-channel FSM.** States are IDLE, PRESS_WAIT, HELD and RELEASE_WAIT. It uses a debounce counter `dcnt` (8 bit), a hold counter `hcnt` (width `$clog2(LONG_PRESS_MS+1)`, saturating) and a `long_done` flag.
  - IDLE: if `act`, go to PRESS_WAIT with `dcnt` = 0.
  - PRESS_WAIT:
    - If `!act` in any cycle, return to IDLE with `dcnt` cleared.
    - Otherwise, on `tick`, `dcnt`++.
    - On a tick where `dcnt == DEBOUNCE_MS-1`, go to HELD, set `level_o`, pulse `press_o`, and clear `hcnt` and `long_done`.
  - HELD:
    - On `tick`, `hcnt`++ (saturating).
    - When `hcnt` reaches `LONG_PRESS_MS` and `!long_done`, pulse `long_o` and set `long_done`.
    - If `!act`, go to RELEASE_WAIT with `dcnt` = 0.
  - RELEASE_WAIT:
    - `hcnt` is frozen.
    - If `act`, return to HELD. No pulse is emitted, and `hcnt` and `long_done` are retained.
    - On a tick where `dcnt == DEBOUNCE_MS-1`, go to IDLE, clear `level_o` and pulse `release_o`.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- `long_o` never repeats within one press. A release accepted before `LONG_PRESS_MS` produces no `long_o`.
- `press_o`, `release_o` and `long_o` are mutually exclusive per channel per cycle.

## Timing
- All outputs are registered. The reset value of `level_o`, `press_o`, `release_o` and `long_o` is all-zero. Reset also clears the prescaler, FSMs and counters.
- Reset asserted mid-press: outputs clear on the next edge. If the button is still held after reset, a full debounce runs and `press_o` fires again.
- Latency, `btn_i` edge to `press_o`/`level_o`: 2 synchroniser cycles + `DEBOUNCE_MS` ticks. In SIM, that is `DEBOUNCE_MS`+2 cycles.
- `press_o` and the rise of `level_o` are in the same cycle. `release_o` and the fall of `level_o` are in the same cycle.
- `long_o` fires exactly `LONG_PRESS_MS` ticks after `press_o`, excluding ticks spent in RELEASE_WAIT.
- A bounce that returns to the current stable level resets debounce timing in the same cycle, whether or not a tick is present.

## Structure
- Package `lscc_btn_pkg` holds:
  - the typedef enum `btn_state_e` (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT);
  - `localparam TICK_HZ = 1000`.
- Sub-module `btn_channel`: synchroniser, FSM and counters for one channel. It is instanced `NUM_BTN` times by generate and takes the shared `tick` as an input.
- The top level owns the prescaler, with `SIM` bypass, and the generate loop.

## Test plan
All scenarios use SIM, DEBOUNCE_MS=4, LONG_PRESS_MS=16, BTN_POLARITY=0.

1. Reset with `btn_i`=4'hF → all outputs 0, and they stay 0 indefinitely.
2. Clean press: `btn_i[0]` goes low at cycle 0 → `press_o[0]` pulses and `level_o[0]` rises at cycle 6. There is no `long_o` if the button is released at cycle 10, and `release_o[0]` fires at cycle 16.
3. Bounce: `btn_i[1]` toggles low/high every 2 cycles for 20 cycles, then stays low → exactly one `press_o[1]`, 6 cycles after the final low edge.
4. Long press: hold `btn_i[2]` low → `long_o[2]` fires exactly 16 cycles after `press_o[2]`, once only. A release glitch of 2 cycles at hold-count 8 gives no `release_o`, and `long_o` shifts by the frozen cycles.
5. Simultaneous: all four channels pressed in the same cycle → `press_o`=4'hF in a single cycle. Releasing channel 3 only gives `release_o`=4'h8.
6. Reset mid-hold: assert `rstn_i` while `level_o[0]`=1 with the button still held → `level_o` is 0 the cycle after reset. After deassertion, `press_o[0]` fires again 6 cycles later.
